// File: rtl/mdu_sequencer_pkg.sv
// mdu_sequencer_pkg: MDU op encodings, default latencies and op classification helpers
package mdu_sequencer_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Ops that occupy the unit for several cycles
    function automatic logic is_long_op(logic [2:0] op);
        return op == MDU_MULT || op == MDU_MULTU || op == MDU_DIV || op == MDU_DIVU;
    endfunction

    // Any op the unit acts on; 0 and 7 are ignored
    function automatic logic is_valid_op(logic [2:0] op);
        return op != MDU_NONE && op != MDU_RSVD;
    endfunction

endpackage

// File: rtl/mdu_sequencer_arith.sv
// mdu_arith: combinational product/quotient/remainder producing the pending {hi,lo}
module mdu_arith
    import mdu_sequencer_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] pend
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic        is_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q_s;
    logic [31:0] r_s;

    // Signed divide works on magnitudes so INT_MIN/-1 wraps to INT_MIN; b==0 keeps the old {hi,lo}
    always_comb begin
        prod_s     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u     = {32'd0, a} * {32'd0, b};
        signed_div = op == MDU_DIV;
        is_div     = op == MDU_DIV || op == MDU_DIVU;
        mag_a      = (signed_div && a[31]) ? -a : a;
        mag_b      = (signed_div && b[31]) ? -b : b;
        div_b      = (b == 32'd0) ? 32'd1 : mag_b;
        uq         = mag_a / div_b;
        ur         = mag_a % div_b;
        q_s        = (signed_div && (a[31] ^ b[31])) ? -uq : uq;
        r_s        = (signed_div && a[31]) ? -ur : ur;
        pend       = (op == MDU_MULT)               ? prod_s :
                     (op == MDU_MULTU)              ? prod_u :
                     (is_div && b != 32'd0)         ? {r_s, q_s} :
                                                      {hi, lo};
    end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: E-stage MDU latency counter, HI/LO owner and D-stage stall source
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_mdu_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic [63:0]      pend;
    logic             idle;
    logic             accept;
    logic             is_mul;

    assign idle   = cnt == '0;
    assign accept = start & idle & is_valid_op(op);
    assign is_mul = op == MDU_MULT || op == MDU_MULTU;
    assign busy   = (start & is_long_op(op)) | ~idle;
    assign stall  = d_mdu_use & busy;

    mdu_arith u_arith (
        .op   (op),
        .a    (a),
        .b    (b),
        .hi   (hi),
        .lo   (lo),
        .pend (pend)
    );

    // Latch the result on accept, count down, and commit it to HI/LO on the last busy edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (accept) begin
            if (is_long_op(op)) begin
                pend_hi <= pend[63:32];
                pend_lo <= pend[31:0];
                cnt     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end
            if (op == MDU_MTHI) hi <= a;
            if (op == MDU_MTLO) lo <= a;
        end else if (!idle) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed vectors checked against an edge-timestamp model of the MDU
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        d_mdu_use = 1'b0;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int passes = 0;

    mdu_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .d_mdu_use (d_mdu_use),
        .busy      (busy),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Architectural result of an op, from plain 64-bit arithmetic
    function automatic logic [63:0] result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] h, input logic [31:0] l);
        longint sx, sy, q, r;
        logic [63:0] ux, uy, uq, ur;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (o == 3'd1) return 64'(sx * sy);
        if (o == 3'd2) return ux * uy;
        if (y == 32'd0) return {h, l};
        if (o == 3'd3) begin
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
        end
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
    endfunction

    // Model: e numbers rising edges, land is the edge at which the in-flight result commits
    int          e = 0;
    int          land = 0;
    logic [31:0] mhi = 0, mlo = 0, nhi = 0, nlo = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e    <= 0;
            land <= 0;
            mhi  <= 0;
            mlo  <= 0;
        end else begin : step
            logic [63:0] r;
            e <= e + 1;
            if (e + 1 == land) begin
                mhi <= nhi;
                mlo <= nlo;
            end
            if (start && e + 1 > land) begin
                if (op >= 3'd1 && op <= 3'd4) begin
                    r = result(op, a, b, mhi, mlo);
                    nhi  <= r[63:32];
                    nlo  <= r[31:0];
                    land <= e + 1 + ((op <= 3'd2) ? 5 : 10);
                end else if (op == 3'd5) mhi <= a;
                else if (op == 3'd6) mlo <= a;
            end
        end
    end

    int brun = 0, blast = 0, srun = 0, slast = 0;
    logic exp_busy;

    // Per-cycle comparison away from the active edge, plus run-length tracking of busy/stall
    always @(negedge clk) begin
        if (!reset) begin
            exp_busy = (start && op >= 3'd1 && op <= 3'd4) || (e < land);
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("stall", {31'd0, stall}, {31'd0, d_mdu_use & exp_busy});
            chk("hi", hi, mhi);
            chk("lo", lo, mlo);
            if (busy) brun++;
            else begin
                if (brun > 0) blast = brun;
                brun = 0;
            end
            if (stall) srun++;
            else begin
                if (srun > 0) slast = srun;
                srun = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        idle(8);
        chk("mult_busy_len", blast, 32'd6);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);

        issue(3'd2, 32'hFFFFFFFE, 32'd3);
        idle(8);
        chk("multu_hi", hi, 32'h00000002);
        chk("multu_lo", lo, 32'hFFFFFFFA);

        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        idle(12);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        issue(3'd4, 32'd7, 32'd2);
        idle(12);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        issue(3'd5, 32'h11, 32'd0);
        idle(1);
        issue(3'd6, 32'h22, 32'd0);
        idle(1);
        chk("mthi", hi, 32'h11);
        chk("mtlo", lo, 32'h22);

        issue(3'd3, 32'd5, 32'd0);
        idle(13);
        chk("div0_busy_len", blast, 32'd11);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);

        d_mdu_use = 1'b1;
        issue(3'd1, 32'h00010000, 32'h00010000);
        idle(1);
        issue(3'd2, 32'd5, 32'd5);
        idle(6);
        d_mdu_use = 1'b0;
        idle(2);
        chk("stall_len", slast, 32'd6);
        chk("b2b_hi", hi, 32'd1);
        chk("b2b_lo", lo, 32'd0);

        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        idle(12);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'd0);

        issue(3'd7, 32'h1234, 32'h5678);
        idle(2);
        issue(3'd0, 32'h1234, 32'h5678);
        idle(2);
        chk("op7_hi", hi, 32'd0);
        chk("op7_lo", lo, 32'h80000000);

        issue(3'd3, 32'd100, 32'd7);
        idle(3);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        #3 reset = 1'b0;
        idle(14);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
